// File: rtl/seg_snake.sv
// rtl/seg_snake.sv - rotating snake of lit segments around the outer ring of a multiplexed 7-segment display
// A speed accumulator paces head steps; the digit scanner shows one digit's slice of the ring at a time.
module seg_snake #(
    parameter int N_DIGITS  = 8,
    parameter int SNAKE_LEN = 5,
    parameter int TICK_MAX  = 100_000_000,
    parameter int SPEED_W   = 8,
    parameter int SCAN_DIV  = 100_000
) (
    input  logic                                CLK100MHZ,
    input  logic                                CPU_RESET,
    input  logic [SPEED_W-1:0]                  SW,
    input  logic                                DIR,
    input  logic                                PAUSE,
    output logic [N_DIGITS-1:0]                 AN,
    output logic [6:0]                          A2G,
    output logic                                DP,
    output logic [$clog2(2*N_DIGITS+4)-1:0]     HEAD
);

    localparam int L      = 2 * N_DIGITS + 4;
    localparam int HW     = $clog2(L);
    localparam int CW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [HW:0]    L_W        = (HW + 1)'(L);
    localparam logic [HW:0]    BACK_W     = (HW + 1)'(SNAKE_LEN - 1);
    localparam logic [HW:0]    LEN_W      = (HW + 1)'(SNAKE_LEN);
    localparam logic [HW-1:0]  HEAD_MAX   = HW'(L - 1);
    localparam logic [HW-1:0]  HEAD_RST   = HW'(SNAKE_LEN - 1);
    localparam logic [31:0]    TICK_LIM   = 32'(TICK_MAX);
    localparam logic [CW-1:0]  SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]  DIGIT_LAST = DW'(N_DIGITS - 1);

    generate
        if (N_DIGITS < 2 || N_DIGITS > 8) begin : g_bad_digits
            $error("seg_snake: N_DIGITS must be 2..8");
        end
        if (SNAKE_LEN < 1 || SNAKE_LEN > L - 1) begin : g_bad_len
            $error("seg_snake: SNAKE_LEN must be 1..L-1");
        end
        if (SCAN_DIV < 1) begin : g_bad_scan
            $error("seg_snake: SCAN_DIV must be at least 1");
        end
        if (64'(TICK_MAX) + 64'd1 + (64'd1 << SPEED_W) >= (64'd1 << 32)) begin : g_acc_overflow
            $error("seg_snake: accumulator can overflow for this TICK_MAX/SPEED_W");
        end
    endgenerate

    logic [31:0]   acc_q, acc_d;
    logic          step_q, step_d;
    logic          dir_q, dir_d;
    logic [HW-1:0] head_q, head_d;
    logic [CW-1:0] scan_q, scan_d;
    logic [DW-1:0] digit_q, digit_d;

    logic [HW:0]   head_w, tail_w, pos_w, dist_w;
    logic [L-1:0]  lit;
    logic [6:0]    seg;

    always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
        if (CPU_RESET) begin
            acc_q   <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            head_q  <= HEAD_RST;
            scan_q  <= '0;
            digit_q <= '0;
        end else begin
            acc_q   <= acc_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            head_q  <= head_d;
            scan_q  <= scan_d;
            digit_q <= digit_d;
        end
    end

    always_comb begin
        acc_d  = acc_q;
        step_d = 1'b0;
        if (!PAUSE) begin
            if (acc_q >= TICK_LIM) begin
                acc_d  = '0;
                step_d = 1'b1;
            end else begin
                acc_d = acc_q + 32'd1 + 32'(SW);
            end
        end
    end

    // A reversal swaps head and tail so the lit set stays put for that step.
    always_comb begin
        head_w = {1'b0, head_q};
        tail_w = head_w;
        head_d = head_q;
        dir_d  = dir_q;
        if (!dir_q) begin
            tail_w = (head_w >= BACK_W) ? head_w - BACK_W : head_w + L_W - BACK_W;
        end else begin
            tail_w = head_w + BACK_W;
            if (tail_w >= L_W) begin
                tail_w = tail_w - L_W;
            end
        end
        if (step_q) begin
            if (DIR != dir_q) begin
                dir_d  = DIR;
                head_d = HW'(tail_w);
            end else if (!dir_q) begin
                head_d = (head_q == HEAD_MAX) ? '0 : head_q + HW'(1);
            end else begin
                head_d = (head_q == '0) ? HEAD_MAX : head_q - HW'(1);
            end
        end
    end

    always_comb begin
        scan_d  = scan_q + CW'(1);
        digit_d = digit_q;
        if (scan_q == SCAN_LAST) begin
            scan_d  = '0;
            digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + DW'(1);
        end
    end

    // Position p is lit when its distance behind the head (in travel direction) is below SNAKE_LEN.
    always_comb begin
        lit    = '0;
        pos_w  = '0;
        dist_w = '0;
        for (int p = 0; p < L; p++) begin
            pos_w = (HW + 1)'(p);
            if (!dir_q) begin
                dist_w = (head_w >= pos_w) ? head_w - pos_w : head_w + L_W - pos_w;
            end else begin
                dist_w = (pos_w >= head_w) ? pos_w - head_w : pos_w + L_W - head_w;
            end
            lit[p] = (dist_w < LEN_W);
        end
    end

    always_comb begin
        seg = '0;
        AN  = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_q == DW'(i)) begin
                AN[i]  = 1'b0;
                seg[0] = lit[N_DIGITS - 1 - i];
                seg[3] = lit[N_DIGITS + 2 + i];
                if (i == 0) begin
                    seg[1] = lit[N_DIGITS];
                    seg[2] = lit[N_DIGITS + 1];
                end
                if (i == N_DIGITS - 1) begin
                    seg[4] = lit[2 * N_DIGITS + 2];
                    seg[5] = lit[2 * N_DIGITS + 3];
                end
            end
        end
    end

    assign A2G  = ~seg;
    assign DP   = 1'b1;
    assign HEAD = head_q;

endmodule

// File: tb/tb_seg_snake.sv
// tb/tb_seg_snake.sv - randomized and directed checks of seg_snake against a ring-position reference model
module tb_seg_snake;

    localparam int N  = 4;
    localparam int S  = 3;
    localparam int TM = 3;
    localparam int SD = 2;
    localparam int L  = 2 * N + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sw = 8'd0;
    logic       dir = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] an;
    logic [6:0] a2g;
    logic       dp;
    logic [3:0] head;

    int n_checks = 0;
    int n_errors = 0;

    int m_acc, m_head, m_scan, m_digit;
    bit m_step, m_dir;

    int head_tbl[9] = '{2, 2, 2, 2, 3, 3, 3, 3, 4};
    logic [3:0] an_tbl[9] = '{4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011,
                              4'b0111, 4'b0111, 4'b1110, 4'b1110};

    always #5 clk = ~clk;

    seg_snake #(
        .N_DIGITS (N),
        .SNAKE_LEN(S),
        .TICK_MAX (TM),
        .SPEED_W  (8),
        .SCAN_DIV (SD)
    ) dut (
        .CLK100MHZ(clk),
        .CPU_RESET(rst),
        .SW       (sw),
        .DIR      (dir),
        .PAUSE    (pause),
        .AN       (an),
        .A2G      (a2g),
        .DP       (dp),
        .HEAD     (head)
    );

    function automatic int wrap(int x);
        return ((x % L) + L) % L;
    endfunction

    function automatic void model_reset();
        m_acc = 0; m_step = 0; m_dir = 0; m_head = S - 1; m_scan = 0; m_digit = 0;
    endfunction

    function automatic void model_clock();
        int  n_head = m_head;
        bit  n_dir  = m_dir;
        if (m_step) begin
            if (dir != m_dir) begin
                n_head = m_dir ? wrap(m_head + S - 1) : wrap(m_head - (S - 1));
                n_dir  = dir;
            end else begin
                n_head = wrap(m_head + (m_dir ? -1 : 1));
            end
        end
        m_step = 0;
        if (!pause) begin
            if (m_acc >= TM) begin
                m_acc  = 0;
                m_step = 1;
            end else begin
                m_acc = m_acc + 1 + int'(sw);
            end
        end
        m_head = n_head;
        m_dir  = n_dir;
        if (m_scan == SD - 1) begin
            m_scan  = 0;
            m_digit = (m_digit + 1) % N;
        end else begin
            m_scan = m_scan + 1;
        end
    endfunction

    function automatic void pos_to_seg(input int p, output int d, output int s);
        if (p < N)               begin d = N - 1 - p; s = 0; end
        else if (p == N)         begin d = 0;         s = 1; end
        else if (p == N + 1)     begin d = 0;         s = 2; end
        else if (p <= 2 * N + 1) begin d = p - N - 2; s = 3; end
        else if (p == 2 * N + 2) begin d = N - 1;     s = 4; end
        else                     begin d = N - 1;     s = 5; end
    endfunction

    function automatic logic [6:0] exp_a2g();
        logic [6:0] m = 7'h7F;
        int d, s, p;
        for (int k = 0; k < S; k++) begin
            p = m_dir ? wrap(m_head + k) : wrap(m_head - k);
            pos_to_seg(p, d, s);
            if (d == m_digit) m[s] = 1'b0;
        end
        return m;
    endfunction

    function automatic logic [3:0] exp_an();
        logic [3:0] v = 4'hF;
        v[m_digit] = 1'b0;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_clock();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (head !== 4'd2) begin n_errors++; $display("FAIL reset_head got=%0d want=2", head); end
        n_checks++;
        if (an !== 4'b1110) begin n_errors++; $display("FAIL reset_an got=%b want=1110", an); end
        n_checks++;
        if (a2g !== 7'h7F) begin n_errors++; $display("FAIL reset_a2g got=%b want=1111111", a2g); end
        n_checks++;
        if (dp !== 1'b1) begin n_errors++; $display("FAIL reset_dp got=%b want=1", dp); end
    endtask

    task automatic test_basic_timing();
        sw = 8'd0; dir = 1'b0; pause = 1'b0;
        rst = 1'b0;
        for (int e = 0; e < 9; e++) begin
            tick();
            n_checks++;
            if (head !== 4'(head_tbl[e]) || head !== 4'(m_head))
                begin n_errors++; $display("FAIL timing_head edge=%0d got=%0d want=%0d", e + 1, head, head_tbl[e]); end
            n_checks++;
            if (an !== an_tbl[e])
                begin n_errors++; $display("FAIL timing_an edge=%0d got=%b want=%b", e + 1, an, an_tbl[e]); end
        end
    endtask

    task automatic test_speed();
        int h0;
        sw = 8'd3;
        repeat (4) tick();
        h0 = int'(head);
        for (int c = 0; c < 16; c++) begin
            tick();
            n_checks++;
            if ({head, an, a2g} !== {4'(m_head), exp_an(), exp_a2g()})
                begin n_errors++; $display("FAIL speed head=%0d/%0d an=%b/%b a2g=%b/%b", head, m_head, an, exp_an(), a2g, exp_a2g()); end
        end
        n_checks++;
        if (wrap(int'(head) - h0) != 8)
            begin n_errors++; $display("FAIL speed_rate advanced=%0d want=8", wrap(int'(head) - h0)); end
    endtask

    task automatic test_wrap();
        bit seen = 0;
        bit found = 0;
        int prev;
        sw = 8'd0;
        for (int c = 0; c < 200 && !seen; c++) begin
            prev = int'(head);
            tick();
            if (prev == L - 1 && head == 4'd0) seen = 1;
        end
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL wrap_head got=%0d want=11->0", head); end
        pause = 1'b1;
        for (int c = 0; c < 10 && !found; c++) begin
            tick();
            if (an == 4'b0111) found = 1;
        end
        n_checks++;
        if (!found || a2g !== 7'b1001110 || a2g !== exp_a2g())
            begin n_errors++; $display("FAIL wrap_digit3 an=%b a2g=%b want=1001110", an, a2g); end
        pause = 1'b0;
    endtask

    task automatic test_reverse();
        bit ok = 0;
        bit found;
        int prev;
        sw = 8'd0; dir = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            tick();
            if (head == 4'd5) ok = 1;
        end
        dir = 1'b1;
        prev = int'(head);
        for (int c = 0; c < 10 && int'(head) == prev; c++) tick();
        n_checks++;
        if (!ok || head !== 4'd3) begin n_errors++; $display("FAIL reverse_head got=%0d want=3", head); end
        pause = 1'b1;
        found = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++;
            if ({head, an, a2g} !== {4'(m_head), exp_an(), exp_a2g()})
                begin n_errors++; $display("FAIL reverse_lit head=%0d/%0d an=%b/%b a2g=%b/%b", head, m_head, an, exp_an(), a2g, exp_a2g()); end
            if (an == 4'b1110 && !found) begin
                found = 1;
                n_checks++;
                if (a2g !== 7'b1111000) begin n_errors++; $display("FAIL reverse_digit0 got=%b want=1111000", a2g); end
            end
        end
        pause = 1'b0;
        prev = int'(head);
        for (int c = 0; c < 10 && int'(head) == prev; c++) tick();
        n_checks++;
        if (head !== 4'd2) begin n_errors++; $display("FAIL reverse_step got=%0d want=2", head); end
        pause = 1'b1;
        found = 0;
        for (int c = 0; c < 8 && !found; c++) begin
            tick();
            if (an == 4'b1110) found = 1;
        end
        n_checks++;
        if (!found || a2g !== 7'b1111100) begin n_errors++; $display("FAIL reverse_digit0b got=%b want=1111100", a2g); end
        pause = 1'b0;
    endtask

    task automatic test_pause();
        int h;
        sw = 8'd0;
        repeat (2) tick();
        pause = 1'b1;
        tick();
        h = int'(head);
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++;
            if (head !== 4'(h) || head !== 4'(m_head))
                begin n_errors++; $display("FAIL pause_frozen cycle=%0d got=%0d want=%0d", c, head, h); end
        end
        pause = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if ({head, an, a2g} !== {4'(m_head), exp_an(), exp_a2g()})
                begin n_errors++; $display("FAIL pause_resume head=%0d/%0d an=%b/%b a2g=%b/%b", head, m_head, an, exp_an(), a2g, exp_a2g()); end
        end
    endtask

    task automatic test_reset_mid();
        bit armed = 0;
        sw = 8'd1;
        dir = ~m_dir;
        for (int c = 0; c < 20 && !armed; c++) begin
            tick();
            if (m_step) armed = 1;
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (head !== 4'd2 || an !== 4'b1110 || a2g !== 7'h7F)
            begin n_errors++; $display("FAIL midreset head=%0d an=%b a2g=%b want=2 1110 1111111", head, an, a2g); end
        sw = 8'd0; dir = 1'b0;
        tick();
        rst = 1'b0;
        for (int e = 0; e < 9; e++) begin
            tick();
            n_checks++;
            if (head !== 4'(head_tbl[e]) || an !== an_tbl[e])
                begin n_errors++; $display("FAIL midreset_resume edge=%0d head=%0d/%0d an=%b/%b", e + 1, head, head_tbl[e], an, an_tbl[e]); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            sw    = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            pause = ($urandom_range(0, 9) == 0);
            tick();
            n_checks++;
            if ({head, an, a2g, dp} !== {4'(m_head), exp_an(), exp_a2g(), 1'b1})
                begin n_errors++; $display("FAIL random cycle=%0d head=%0d/%0d an=%b/%b a2g=%b/%b", c, head, m_head, an, exp_an(), a2g, exp_a2g()); end
        end
        pause = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_timing();
        test_speed();
        test_wrap();
        test_reverse();
        test_pause();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
